// File: rtl/osd_stm_pkg.sv
// Shared definitions for the STM marker snoop: marker encoding, the
// overflow event id and the queued event record.
package osd_stm_pkg;

  // A marker is "addi x0, x0, imm" with a non-zero immediate.
  localparam logic [6:0]  MARKER_OPCODE = 7'h13;
  localparam logic [2:0]  MARKER_FUNCT3 = 3'b000;
  localparam logic [4:0]  MARKER_RD     = 5'd0;
  localparam logic [4:0]  MARKER_RS1    = 5'd0;

  // Id reserved for the "events were dropped" report.
  localparam logic [15:0] OVF_ID        = 16'hFFFF;

  // Queued values are held at 64 bits; the top narrows them to XLEN (XLEN <= 64).
  localparam int          EVT_VALUE_W   = 64;

  typedef struct packed {
    logic [15:0]            id;
    logic [EVT_VALUE_W-1:0] value;
  } stm_event_t;

  function automatic logic is_marker(input logic [31:0] insn);
    return (insn[6:0]   == MARKER_OPCODE) &&
           (insn[14:12] == MARKER_FUNCT3) &&
           (insn[11:7]  == MARKER_RD)     &&
           (insn[19:15] == MARKER_RS1)    &&
           (insn[31:20] != 12'd0);
  endfunction

  function automatic logic [15:0] marker_id(input logic [31:0] insn);
    return {4'h0, insn[31:20]};
  endfunction

endpackage

// File: rtl/osd_stm_evq.sv
// Event queue accepting up to two pushes and one pop per cycle.
// The caller never pushes more than the reported free space.
module osd_stm_evq #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push_cnt,
  input  logic [WIDTH-1:0] push_data0,
  input  logic [WIDTH-1:0] push_data1,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    free
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_en;

  assign pop_en    = pop && (count != '0);
  assign head_data = mem[rd_ptr];
  assign free      = CW'(DEPTH) - count + CW'(pop_en);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_en);
      count  <= count + CW'(push_cnt) - CW'(pop_en);
    end
  end

  // Storage writes, older entry first.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr] <= push_data0;
    if (push_cnt == 2'd2) mem[wr_ptr + PW'(1)] <= push_data1;
  end

endmodule

// File: rtl/osd_stm_snoop.sv
// Snoops the dual-issue retire stream for "addi x0,x0,imm" markers and
// emits {id, value} events on the STM trace port, reporting drops.
module osd_stm_snoop
  import osd_stm_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int VALUE_REG = 10,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           commit_valid,
  input  logic [1:0][31:0]     commit_insn,
  input  logic [1:0]           wb_valid,
  input  logic [1:0][4:0]      wb_addr,
  input  logic [1:0][XLEN-1:0] wb_data,
  output logic                 trace_valid,
  output logic [15:0]          trace_id,
  output logic [XLEN-1:0]      trace_value
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] shadow;
  logic [15:0]     drop_cnt;
  logic [1:0]      is_mk;
  logic [1:0]      wb_hit;
  logic [1:0]      n_mk;
  logic [1:0]      n_drop;
  logic [1:0]      q_push_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   q_free;
  logic            q_empty;
  logic            bypass;
  logic            ovf_emit;
  logic [16:0]     drop_sum;
  stm_event_t      ev0, ev1, ev_first, q_d0, q_head;

  // Per-lane marker decode and shadow-register write detection.
  always_comb begin
    is_mk  = '0;
    wb_hit = '0;
    for (int i = 0; i < 2; i++) begin
      is_mk[i]  = commit_valid[i] && is_marker(commit_insn[i]);
      wb_hit[i] = wb_valid[i] && (wb_addr[i] == 5'(VALUE_REG)) && (wb_addr[i] != 5'd0);
    end
  end

  // Lane 1 sees lane 0's same-cycle write of the value register.
  assign ev0.id    = marker_id(commit_insn[0]);
  assign ev0.value = EVT_VALUE_W'(shadow);
  assign ev1.id    = marker_id(commit_insn[1]);
  assign ev1.value = wb_hit[0] ? EVT_VALUE_W'(wb_data[0]) : EVT_VALUE_W'(shadow);
  assign ev_first  = is_mk[0] ? ev0 : ev1;

  assign n_mk     = {1'b0, is_mk[0]} + {1'b0, is_mk[1]};
  assign q_empty  = (q_count == '0);
  assign ovf_emit = q_empty && (n_mk == 2'd0) && (drop_cnt != 16'd0);
  assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
  assign q_d0     = q_empty ? ev1 : ev_first;

  // Empty queue: oldest marker bypasses straight to the output register.
  // Otherwise markers beyond the free space are dropped, newest first.
  always_comb begin
    bypass     = 1'b0;
    q_push_cnt = 2'd0;
    n_drop     = 2'd0;
    if (q_empty) begin
      bypass     = (n_mk != 2'd0);
      q_push_cnt = (n_mk == 2'd2) ? 2'd1 : 2'd0;
    end else if (CW'(n_mk) <= q_free) begin
      q_push_cnt = n_mk;
    end else begin
      q_push_cnt = q_free[1:0];
      n_drop     = n_mk - q_free[1:0];
    end
  end

  osd_stm_evq #(
    .WIDTH($bits(stm_event_t)),
    .DEPTH(QDEPTH)
  ) u_evq (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (q_push_cnt),
    .push_data0(q_d0),
    .push_data1(ev1),
    .pop       (!q_empty),
    .head_data (q_head),
    .count     (q_count),
    .free      (q_free)
  );

  // Shadow copy of the value register; lane 1 is younger and wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           shadow <= '0;
    else if (wb_hit[1]) shadow <= wb_data[1];
    else if (wb_hit[0]) shadow <= wb_data[0];
  end

  // Saturating drop counter, reloaded when its count is reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             drop_cnt <= '0;
    else if (ovf_emit)    drop_cnt <= 16'(n_drop);
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                  drop_cnt <= drop_sum[15:0];
  end

  // Registered trace port: queue head, bypassed marker, or overflow report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_valid <= 1'b0;
      trace_id    <= '0;
      trace_value <= '0;
    end else if (!q_empty) begin
      trace_valid <= 1'b1;
      trace_id    <= q_head.id;
      trace_value <= XLEN'(q_head.value);
    end else if (bypass) begin
      trace_valid <= 1'b1;
      trace_id    <= ev_first.id;
      trace_value <= XLEN'(ev_first.value);
    end else if (ovf_emit) begin
      trace_valid <= 1'b1;
      trace_id    <= OVF_ID;
      trace_value <= XLEN'(drop_cnt);
    end else begin
      trace_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_osd_stm_snoop.sv
// Self-checking bench for osd_stm_snoop: vector table plus hand-written
// burst/overflow/reset sequences, all checked through an event scoreboard.
module tb_osd_stm_snoop;

  logic             clk;
  logic             rst;
  logic [1:0]       commit_valid;
  logic [1:0][31:0] commit_insn;
  logic [1:0]       wb_valid;
  logic [1:0][4:0]  wb_addr;
  logic [1:0][63:0] wb_data;
  logic             trace_valid;
  logic [15:0]      trace_id;
  logic [63:0]      trace_value;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] id;
    logic [63:0] value;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [1:0]  cv;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  wv;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [63:0] d0;
    logic [63:0] d1;
    int          n_exp;
    logic [15:0] id0;
    logic [63:0] val0;
    logic [15:0] id1;
    logic [63:0] val1;
  } vec_t;

  vec_t vecs[14];

  osd_stm_snoop #(
    .XLEN(64),
    .VALUE_REG(10),
    .QDEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .commit_valid(commit_valid),
    .commit_insn (commit_insn),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .trace_valid (trace_valid),
    .trace_id    (trace_id),
    .trace_value (trace_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_event(input logic [15:0] id, input logic [63:0] value);
    exp_t e;
    e.id    = id;
    e.value = value;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] marker(input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, 5'd0, 7'h13};
  endfunction

  task automatic drive_idle();
    commit_valid = '0;
    commit_insn  = '0;
    wb_valid     = '0;
    wb_addr      = '0;
    wb_data      = '0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    if (v.n_exp > 0) expect_event(v.id0, v.val0);
    if (v.n_exp > 1) expect_event(v.id1, v.val1);
    @(negedge clk);
    commit_valid   = v.cv;
    commit_insn[0] = v.i0;
    commit_insn[1] = v.i1;
    wb_valid       = v.wv;
    wb_addr[0]     = v.a0;
    wb_addr[1]     = v.a1;
    wb_data[0]     = v.d0;
    wb_data[1]     = v.d1;
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic write_a0(input logic [63:0] val);
    @(negedge clk);
    drive_idle();
    wb_valid   = 2'b01;
    wb_addr[0] = 5'd10;
    wb_data[0] = val;
    @(negedge clk);
    drive_idle();
  endtask

  // Dual markers every cycle; ids base, base+1, ... in commit order. Ends on a negedge with inputs idle.
  task automatic run_burst(input int ncyc, input logic [11:0] base);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      commit_valid   = 2'b11;
      commit_insn[0] = marker(base + 12'(2 * k));
      commit_insn[1] = marker(base + 12'(2 * k + 1));
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, 64'(trace_valid), 64'd0);
    check_output({tag, "_id"}, 64'(trace_id), 64'd0);
    check_output({tag, "_value"}, trace_value, 64'd0);
  endtask

  // Scoreboard: every trace_valid cycle must match the oldest expected event.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst && trace_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got id %h value %h expected no event", trace_id, trace_value);
      end else begin
        e = sbq.pop_front();
        check_output("trace_id", 64'(trace_id), 64'(e.id));
        check_output("trace_value", trace_value, e.value);
      end
    end
  end

  initial begin
    drive_idle();
    rst = 1'b0;

    vecs[0]  = '{2'b00, 32'h0, 32'h0, 2'b01, 5'd10, 5'd0, 64'h1111, 64'h0, 0, 16'h0, 64'h0, 16'h0, 64'h0};
    vecs[1]  = '{2'b01, 32'h02A00013, 32'h0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1, 16'h002A, 64'h1111, 16'h0, 64'h0};
    vecs[2]  = '{2'b10, 32'h0, 32'h00700013, 2'b01, 5'd10, 5'd0, 64'h55, 64'h0, 1, 16'h0007, 64'h55, 16'h0, 64'h0};
    vecs[3]  = '{2'b11, 32'h00100013, 32'h00200013, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2, 16'h0001, 64'h55, 16'h0002, 64'h55};
    vecs[4]  = '{2'b11, 32'h00000013, 32'h00100093, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 0, 16'h0, 64'h0, 16'h0, 64'h0};
    vecs[5]  = '{2'b11, 32'h00300013, 32'h00400013, 2'b11, 5'd10, 5'd10, 64'hAAAA, 64'hBBBB, 2, 16'h0003, 64'h55, 16'h0004, 64'hAAAA};
    vecs[6]  = '{2'b10, 32'h0, 32'h00500013, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1, 16'h0005, 64'hBBBB, 16'h0, 64'h0};
    vecs[7]  = '{2'b10, 32'h00600013, 32'h00108013, 2'b10, 5'd10, 5'd0, 64'h777, 64'hDEAD, 0, 16'h0, 64'h0, 16'h0, 64'h0};
    vecs[8]  = '{2'b01, 32'h00800013, 32'h0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1, 16'h0008, 64'hBBBB, 16'h0, 64'h0};
    vecs[9]  = '{2'b10, 32'h0, 32'h00900013, 2'b10, 5'd0, 5'd11, 64'h0, 64'h999, 1, 16'h0009, 64'hBBBB, 16'h0, 64'h0};
    vecs[10] = '{2'b11, 32'h02A01013, 32'hFFF00013, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1, 16'h0FFF, 64'hBBBB, 16'h0, 64'h0};
    vecs[11] = '{2'b01, 32'h01000013, 32'h0, 2'b10, 5'd0, 5'd10, 64'h0, 64'hFEDCBA9876543210, 1, 16'h0010, 64'hBBBB, 16'h0, 64'h0};
    vecs[12] = '{2'b10, 32'h0, 32'h01100013, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1, 16'h0011, 64'hFEDCBA9876543210, 16'h0, 64'h0};
    vecs[13] = '{2'b10, 32'h0, 32'h01200013, 2'b01, 5'd10, 5'd0, 64'h1, 64'h0, 1, 16'h0012, 64'h1, 16'h0, 64'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write a0, then marker next cycle: trace_valid exactly one cycle after the commit
    wb_valid   = 2'b01;
    wb_addr[0] = 5'd10;
    wb_data[0] = 64'h1234;
    @(posedge clk);
    #2;
    check_output("lat_before_commit", 64'(trace_valid), 64'd0);
    @(negedge clk);
    drive_idle();
    commit_valid   = 2'b01;
    commit_insn[0] = 32'h02A00013;
    expect_event(16'h002A, 64'h1234);
    @(posedge clk);
    #2;
    check_output("lat_after_commit", 64'(trace_valid), 64'd1);
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    // Vector table
    for (int i = 0; i < 14; i++) apply_stimulus(vecs[i]);

    // Six cycles of dual markers into a 4-deep queue: ids 0x10A and 0x10C are dropped
    write_a0(64'hC0DE);
    for (int k = 0; k < 9; k++) expect_event(16'h0101 + 16'(k), 64'hC0DE);
    expect_event(16'h010B, 64'hC0DE);
    expect_event(16'hFFFF, 64'd2);
    run_burst(6, 12'h101);
    repeat (16) @(negedge clk);
    check_output("overflow_drained", 64'(sbq.size()), 64'd0);

    // Same overload, but reset before the queue drains: no stale events, no drop report
    for (int k = 0; k < 6; k++) expect_event(16'h0201 + 16'(k), 64'hC0DE);
    run_burst(6, 12'h201);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_drops");
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check_output("rst_drops_drained", 64'(sbq.size()), 64'd0);
    commit_valid   = 2'b01;
    commit_insn[0] = marker(12'h0AB);
    expect_event(16'h00AB, 64'h0);
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    // Three events still queued when reset hits
    for (int k = 0; k < 3; k++) expect_event(16'h0301 + 16'(k), 64'h0);
    run_burst(3, 12'h301);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_queued");
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    wb_valid       = 2'b01;
    wb_addr[0]     = 5'd10;
    wb_data[0]     = 64'h42;
    commit_valid   = 2'b10;
    commit_insn[1] = marker(12'h0CD);
    expect_event(16'h00CD, 64'h42);
    @(negedge clk);
    drive_idle();
    repeat (6) @(negedge clk);

    check_output("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
